ser2par_buffered: RTL



---
 rtl/ser2par_buffered.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ser2par_buffered.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ser2par_buffered
// Description : Parametrised serial-to-parallel deserialiser feeding a
//               one-deep output buffer with a valid/ready handshake. While
//               the consumer drains one word, the next can already be shifted.
//
//   Parameters
//     WIDTH      output word width (must be a multiple of LANES)
//     LANES      serial bits accepted per beat
//     MSB_FIRST  0: first beat fills the low bits, 1: first beat fills the high bits
//
//   Ports
//     clk_in        clock, rising edge
//     rst_in        asynchronous active-low reset
//     clr_in        synchronous discard of a partial word (ignored in HOLD)
//     serial_in     LANES bits of serial data for the current beat
//     wr_in         beat strobe; accepted when wr_in && in_ready
//     in_ready      deserialiser can take a beat (state != HOLD)
//     out_valid     parallel_out holds an undelivered word
//     out_ready     consumer takes the word when out_valid && out_ready
//     parallel_out  assembled word, stable while out_valid=1
//     parity_err    parity flag travelling with parallel_out
//
//   Build option
//     SER_PARITY_EN  when defined, every word takes one extra beat carrying an
//                    even-parity bit on serial_in[0]; parity_err reports a
//                    mismatch. When undefined, parity_err is tied to 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module ser2par_buffered #(
    parameter int WIDTH     = 32,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clr_in,
    input  logic [LANES-1:0] serial_in,
    input  logic             wr_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parallel_out,
    output logic             parity_err
);

    localparam int c_BEATS = WIDTH / LANES;
`ifdef SER_PARITY_EN
    localparam int c_PAR_BEATS = 1;
`else
    localparam int c_PAR_BEATS = 0;
`endif
    // Total beats per word, including the trailing parity beat when enabled.
    localparam int c_TOT   = c_BEATS + c_PAR_BEATS;
    localparam int c_CNT_W = (c_TOT > 1) ? $clog2(c_TOT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_TOT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_out;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_last;
    logic               w_drain;
    logic               w_buf_free;
    logic               w_load_direct;
    logic               w_enter_hold;
    logic               w_load_hold;
    logic [WIDTH-1:0]   w_sr_next;

    // clr_in wins over wr_in, so a beat presented alongside clr_in is dropped.
    assign w_accept      = wr_in && (r_state != S_HOLD) && !clr_in;
    assign w_last        = (r_cnt == c_LAST);
    assign w_drain       = r_out_valid && out_ready;
    // The buffer can take a new word at this edge if empty or being drained now.
    assign w_buf_free    = !r_out_valid || out_ready;
    assign w_load_direct = w_accept && w_last && w_buf_free;
    assign w_enter_hold  = w_accept && w_last && !w_buf_free;
    assign w_load_hold   = (r_state == S_HOLD) && w_drain;

    // Shift register with the current beat's slice merged in. The parity beat
    // (counter == c_BEATS) matches no slice and leaves the data untouched, so
    // w_sr_next is the finished word on the final beat in both build variants.
    always_comb begin
        w_sr_next = r_sr;
        for (int b = 0; b < c_BEATS; b++) begin
            if (w_accept && (r_cnt == c_CNT_W'(b))) begin
                if (MSB_FIRST != 0) begin
                    w_sr_next[WIDTH - (b + 1) * LANES +: LANES] = serial_in;
                end else begin
                    w_sr_next[b * LANES +: LANES] = serial_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Only changes on an accepted beat, so in HOLD it keeps the word.
            r_sr <= w_sr_next;

            case (r_state)
                S_IDLE, S_SHIFT: begin
                    if (clr_in) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= w_buf_free ? S_IDLE : S_HOLD;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_drain) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase

            // Output buffer: parallel_out changes only when a word is loaded.
            if (w_load_direct) begin
                r_out       <= w_sr_next;
                r_out_valid <= 1'b1;
            end else if (w_load_hold) begin
                r_out       <= r_sr;
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SER_PARITY_EN
    logic r_par_err;
    logic r_hold_err;
    logic w_err;

    // On the parity beat r_sr already holds the complete data word.
    assign w_err = (^r_sr) ^ serial_in[0];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_par_err  <= 1'b0;
            r_hold_err <= 1'b0;
        end else begin
            if (w_enter_hold) begin
                r_hold_err <= w_err;
            end
            if (w_load_direct) begin
                r_par_err <= w_err;
            end else if (w_load_hold) begin
                r_par_err <= r_hold_err;
            end
        end
    end

    assign parity_err = r_par_err;
`else
    logic w_unused_hold;
    assign w_unused_hold = w_enter_hold;
    assign parity_err    = 1'b0;
`endif

    assign in_ready     = (r_state != S_HOLD);
    assign out_valid    = r_out_valid;
    assign parallel_out = r_out;

endmodule
`default_nettype wire
